// File: rtl/tpu_run_ctrl.sv
// rtl/tpu_run_ctrl.sv - run controller: core reset, one-cycle start, then wait for all cores done or timeout.
// Optional timeout comparator enabled by defining TPU_RUN_CTRL_TIMEOUT_EN.
module tpu_run_ctrl #(
    parameter int N_CORES      = 1,
    parameter int RESET_CYCLES = 4,
    parameter int CNT_W        = 32,
    parameter int TIMEOUT      = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_CORES-1:0] core_done,
    output logic               core_reset,
    output logic               core_start,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [N_CORES-1:0] done_mask,
    output logic [CNT_W-1:0]   cycle_count
);

`ifdef TPU_RUN_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [RST_W-1:0]   rst_cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [N_CORES-1:0] mask_next;
    logic               all_done;
    logic               timeout_hit;

    always_comb begin
        cnt_inc     = (cycle_count == {CNT_W{1'b1}}) ? cycle_count : cycle_count + 1'b1;
        mask_next   = done_mask | core_done;
        all_done    = &mask_next;
        timeout_hit = TIMEOUT_EN && (cnt_inc == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            core_reset  <= 1'b1;
            core_start  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            done_mask   <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    core_reset <= (state == S_IDLE);
                    if (start) begin
                        // A new job wipes the previous result before the core is reset.
                        state       <= S_RST;
                        rst_cnt     <= RST_W'(RESET_CYCLES - 1);
                        core_reset  <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        done_mask   <= '0;
                        cycle_count <= '0;
                    end
                end
                S_RST: begin
                    if (rst_cnt == '0) begin
                        state      <= S_LAUNCH;
                        core_reset <= 1'b0;
                        core_start <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                S_LAUNCH: begin
                    state      <= S_RUN;
                    core_start <= 1'b0;
                end
                S_RUN: begin
                    cycle_count <= cnt_inc;
                    done_mask   <= mask_next;
                    // Completion takes priority over a timeout landing on the same cycle.
                    if (all_done || timeout_hit) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= !all_done;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    core_reset <= 1'b1;
                    core_start <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
